// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the imem request/ack handshake, tracks the fetch PC and handles redirects.
// Optional macro FETCH_TIMEOUT_EN adds an 8-bit ack-wait watchdog that parks the FSM in FAULT.
module fetch_sequencer #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h80020000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] pc,
  output logic             misalign_err,
  output logic             fetch_timeout
);

  typedef enum logic [2:0] {BOOT, REQ, HOLD, FLUSH, FAULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic             redir_ok;
  logic             redir_bad;
  logic             waiting;

  function automatic logic [WIDTH-1:0] seq_next(input logic [WIDTH-1:0] a);
    return a + WIDTH'(4);
  endfunction

  function automatic logic word_aligned(input logic [WIDTH-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

  assign imem_addr = pc;
  assign waiting   = (state == REQ) || (state == FLUSH);
  assign redir_ok  = redirect_valid && word_aligned(redirect_target);
  assign redir_bad = redirect_valid && !word_aligned(redirect_target);

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       timeout_q;
  assign fetch_timeout = timeout_q;
`else
  assign fetch_timeout = 1'b0;
`endif

  // Redirect target parked while the abandoned request drains in FLUSH
  always_ff @(posedge clock) begin
    if (waiting && redir_ok && !imem_ack) target_q <= redirect_target;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst_data    <= '0;
      inst_pc      <= '0;
      misalign_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tcnt         <= 8'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      misalign_err <= 1'b0;
      unique case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          inst_valid   <= 1'b0;
          misalign_err <= redir_bad;
          if (redir_ok) begin
            if (imem_ack) pc <= redirect_target;
            else          state <= FLUSH;
          end else if (imem_ack) begin
            inst_valid <= 1'b1;
            inst_data  <= imem_rdata;
            inst_pc    <= pc;
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              pc <= seq_next(pc);
            end
          end
        end
        HOLD: begin
          misalign_err <= redir_bad;
          if (redir_ok || !stall) begin
            inst_valid <= 1'b0;
            pc         <= redir_ok ? redirect_target : seq_next(pc);
            state      <= REQ;
            imem_req   <= 1'b1;
          end
        end
        FLUSH: begin
          inst_valid   <= 1'b0;
          misalign_err <= redir_bad;
          // A newer redirect supersedes the parked one; the in-flight ack is dropped either way
          if (imem_ack) begin
            pc    <= redir_ok ? redirect_target : target_q;
            state <= REQ;
          end
        end
        FAULT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
`ifdef FETCH_TIMEOUT_EN
      if (waiting) begin
        if (imem_ack) begin
          tcnt <= 8'd0;
        end else if (tcnt == 8'd254) begin
          tcnt       <= 8'd255;
          state      <= FAULT;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          timeout_q  <= 1'b1;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end else if (state != FAULT) begin
        tcnt <= 8'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of expected (pc, word) pairs, one task per scenario.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] pc;
  logic        misalign_err;
  logic        fetch_timeout;

  fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .pc(pc),
    .misalign_err(misalign_err), .fetch_timeout(fetch_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return a ^ 32'h5A5A0F0F;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fresh();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    tick();
    mpc = RV;
  endtask

  task automatic drive_ack(input logic s);
    imem_ack   = 1'b1;
    stall      = s;
    imem_rdata = word_for(mpc);
    exp_q.push_back(exp_t'{pc: mpc, data: word_for(mpc)});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b0 || fetch_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got req=%b vld=%b mis=%b to=%b exp all 0", imem_req, inst_valid, misalign_err, fetch_timeout);
    end
    checks++;
    if (pc !== RV || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL reset_data got pc=%h data=%h ipc=%h exp %h/0/0", pc, inst_data, inst_pc, RV);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp 1/%h", imem_req, imem_addr, RV);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    start_fresh();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== mpc) begin errors++; $display("FAIL seq_addr got %h exp %h", imem_addr, mpc); end
      drive_ack(1'b0);
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL seq_inst got empty scoreboard exp entry");
      end else begin
        e = exp_q.pop_front();
        if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_data !== e.data) begin
          errors++; $display("FAIL seq_inst got vld=%b pc=%h data=%h exp 1/%h/%h", inst_valid, inst_pc, inst_data, e.pc, e.data);
        end
      end
      mpc = mpc + 32'd4;
    end
    imem_ack = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8002000C) begin
      errors++; $display("FAIL seq_idle got vld=%b req=%b addr=%h exp 0/1/8002000c", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    start_fresh();
    for (int i = 0; i < 2; i++) begin
      drive_ack(i == 1);
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL hold_inst got empty scoreboard exp entry");
      end else begin
        e = exp_q.pop_front();
        if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_data !== e.data) begin
          errors++; $display("FAIL hold_inst got vld=%b pc=%h data=%h exp 1/%h/%h", inst_valid, inst_pc, inst_data, e.pc, e.data);
        end
      end
      if (i == 0) mpc = mpc + 32'd4;
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_data !== word_for(32'h80020004) || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold_stable got vld=%b data=%h req=%b exp 1/%h/0", inst_valid, inst_data, imem_req, word_for(32'h80020004));
      end
      if (i == 2) stall = 1'b0;
      tick();
    end
    mpc = mpc + 32'd4;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80020008) begin
      errors++; $display("FAIL hold_release got vld=%b req=%b addr=%h exp 0/1/80020008", inst_valid, imem_req, imem_addr);
    end
    drive_ack(1'b1);
    tick();
    void'(exp_q.pop_front());
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h80050000;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80050000) begin
      errors++; $display("FAIL hold_redirect got vld=%b req=%b addr=%h exp 0/1/80050000", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    start_fresh();
    redirect_valid = 1'b1;
    redirect_target = 32'h80030000;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== RV) begin
      errors++; $display("FAIL flush_enter got req=%b vld=%b addr=%h exp 1/0/%h", imem_req, inst_valid, imem_addr, RV);
    end
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h80030000 || imem_req !== 1'b1) begin
      errors++; $display("FAIL flush_exit got vld=%b addr=%h req=%b exp 0/80030000/1", inst_valid, imem_addr, imem_req);
    end
    mpc = 32'h80030000;
    drive_ack(1'b0);
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL redirect_inst got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_data !== e.data) begin
        errors++; $display("FAIL redirect_inst got vld=%b pc=%h data=%h exp 1/%h/%h", inst_valid, inst_pc, inst_data, e.pc, e.data);
      end
    end
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80040000;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h80040000) begin
      errors++; $display("FAIL redirect_ack got vld=%b addr=%h exp 0/80040000", inst_valid, imem_addr);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    start_fresh();
    for (int i = 0; i < 2; i++) begin
      drive_ack(1'b0);
      redirect_valid = (i == 0);
      redirect_target = 32'h80030002;
      tick();
      checks++;
      if (misalign_err !== (i == 0)) begin
        errors++; $display("FAIL misalign_pulse got %b exp %b (cycle %0d)", misalign_err, (i == 0), i);
      end
      mpc = mpc + 32'd4;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL misalign_inst got empty scoreboard exp entry");
      end else begin
        e = exp_q.pop_front();
        if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_data !== e.data || imem_addr !== mpc) begin
          errors++; $display("FAIL misalign_inst got vld=%b pc=%h data=%h addr=%h exp 1/%h/%h/%h", inst_valid, inst_pc, inst_data, imem_addr, e.pc, e.data, mpc);
        end
      end
    end
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    start_fresh();
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    mpc = 32'hFFFFFFFC;
    checks++;
    if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_jump got %h exp fffffffc", imem_addr); end
    drive_ack(1'b0);
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL wrap_inst got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_data !== e.data || imem_addr !== 32'h0) begin
        errors++; $display("FAIL wrap_inst got vld=%b pc=%h data=%h addr=%h exp 1/%h/%h/0", inst_valid, inst_pc, inst_data, imem_addr, e.pc, e.data);
      end
    end
    imem_ack = 1'b0;
    repeat (2) tick();
    #3 reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== RV || inst_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got req=%b pc=%h vld=%b exp 0/%h/0", imem_req, pc, inst_valid, RV);
    end
  endtask

  task automatic test_timeout();
    start_fresh();
`ifdef FETCH_TIMEOUT_EN
    repeat (254) tick();
    checks++;
    if (imem_req !== 1'b1 || fetch_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got req=%b to=%b exp 1/0", imem_req, fetch_timeout);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || fetch_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_fire got req=%b to=%b exp 0/1", imem_req, fetch_timeout);
    end
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80060000;
    repeat (5) tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || fetch_timeout !== 1'b1 || imem_addr !== RV) begin
      errors++; $display("FAIL timeout_sticky got req=%b to=%b addr=%h exp 0/1/%h", imem_req, fetch_timeout, imem_addr, RV);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (fetch_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", fetch_timeout); end
`else
    repeat (300) tick();
    checks++;
    if (imem_req !== 1'b1 || fetch_timeout !== 1'b0 || imem_addr !== RV) begin
      errors++; $display("FAIL no_timeout got req=%b to=%b addr=%h exp 1/0/%h", imem_req, fetch_timeout, imem_addr, RV);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect();
    test_misalign();
    test_wrap_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
